// File: rtl/forwarding_hazard_unit.sv
// Operand bypass selection and load-use stall control beside the ID/EX register.
// Optional perf counters (STALL_CYCLES, FWD_COUNT) are built only when FWD_PERF_EN is defined.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ID__RS,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_EX__RS,
  input  logic [REG_ADDR_W-1:0]         ID_EX__RD,
  input  logic                          ID_EX__MEM_READ,
  input  logic                          ID_EX__REG_WRITE,
  input  logic [REG_ADDR_W-1:0]         EX_MEM__RD,
  input  logic                          EX_MEM__REG_WRITE,
  input  logic                          EX_MEM__MEM_READ,
  input  logic [REG_ADDR_W-1:0]         MEM_WB__RD,
  input  logic                          MEM_WB__REG_WRITE,
  input  logic                          FLUSH,
  output logic [NUM_SRC*2-1:0]          SRC,
  output logic                          PC_WRITE,
  output logic                          IF_ID_WRITE,
  output logic                          ID_EX_BUBBLE,
  output logic [31:0]                   STALL_CYCLES,
  output logic [31:0]                   FWD_COUNT
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hz_match;
  logic             hz;
  logic             stall;

  // Load data is still in flight in EX/MEM, so a load there is never a bypass source.
  always_comb begin
    logic [REG_ADDR_W-1:0] rs_ex;
    logic [REG_ADDR_W-1:0] rs_id;
    SRC      = '0;
    hz_match = 1'b0;
    rs_ex    = '0;
    rs_id    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rs_ex = ID_EX__RS[k*REG_ADDR_W +: REG_ADDR_W];
      rs_id = ID__RS[k*REG_ADDR_W +: REG_ADDR_W];
      if (rs_ex != '0 && EX_MEM__REG_WRITE && !EX_MEM__MEM_READ && rs_ex == EX_MEM__RD)
        SRC[k*2 +: 2] = 2'd1;
      else if (rs_ex != '0 && MEM_WB__REG_WRITE && rs_ex == MEM_WB__RD)
        SRC[k*2 +: 2] = 2'd2;
      if (rs_id == ID_EX__RD)
        hz_match = 1'b1;
    end
  end

  assign hz = ID_EX__MEM_READ & ID_EX__REG_WRITE & (ID_EX__RD != '0) & hz_match;

  // The first stall cycle is the IDLE cycle that sees the hazard; WAIT covers the rest.
  always_ff @(posedge clk_i) begin
    if (rst_i || FLUSH) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hz && LOAD_LAT > 1) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(LOAD_LAT - 1);
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign stall = !rst_i && !FLUSH && ((state == S_IDLE && hz) || state == S_WAIT);

  assign PC_WRITE     = !stall;
  assign IF_ID_WRITE  = !stall;
  assign ID_EX_BUBBLE = stall;

`ifdef FWD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
      if (|SRC)
        fwd_cnt <= sat_inc(fwd_cnt);
    end
  end

  assign STALL_CYCLES = stall_cnt;
  assign FWD_COUNT    = fwd_cnt;
`else
  assign STALL_CYCLES = '0;
  assign FWD_COUNT    = '0;
`endif

endmodule

// File: doc/forwarding_hazard_unit.md
# forwarding_hazard_unit

Parametrised forwarding and load-use hazard unit for the 5-stage pipeline. It sits beside the ID/EX register. It selects per-operand bypass sources for any number of EX-stage source operands, never forwards from x0, and does not forward load data from EX/MEM. It detects load-use hazards against the instruction in ID and holds the front end for a configurable multi-cycle memory latency using a small state machine.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- NUM_SRC, 2, number of source operands per instruction (1..4)
- LOAD_LAT, 1, stall cycles per load-use hazard (1..8)

Ports:
- clk_i  in  1  clock; one clock, all state on rising edge
- rst_i  in  1  reset; synchronous, active-high
- ID__RS  in  NUM_SRC*REG_ADDR_W  source indices of instruction in ID; operand k at bits [k*REG_ADDR_W +: REG_ADDR_W]
- ID_EX__RS  in  NUM_SRC*REG_ADDR_W  source indices of instruction in EX, same packing
- ID_EX__RD  in  REG_ADDR_W  destination of instruction in EX
- ID_EX__MEM_READ  in  1  instruction in EX is a load
- ID_EX__REG_WRITE  in  1  instruction in EX writes a register
- EX_MEM__RD, EX_MEM__REG_WRITE, EX_MEM__MEM_READ  in  REG_ADDR_W/1/1  MEM-stage destination, write enable, load flag
- MEM_WB__RD, MEM_WB__REG_WRITE  in  REG_ADDR_W/1  WB-stage destination, write enable
- FLUSH  in  1  taken branch/jump; kills the instructions in IF and ID
- SRC  out  NUM_SRC*2  per-operand select: 0 register file, 1 EX/MEM, 2 MEM/WB (3 never driven)
- PC_WRITE  out  1  PC update enable
- IF_ID_WRITE  out  1  IF/ID register write enable
- ID_EX_BUBBLE  out  1  load a bubble (all control zero) into ID/EX
- STALL_CYCLES  out  32  cycles spent stalled (macro-gated)
- FWD_COUNT  out  32  cycles with at least one nonzero SRC field (macro-gated)

## Operation
- Forwarding is combinational, evaluated for each operand k independently:
  - SRC[k]=1 if RS[k]!=0, EX_MEM__REG_WRITE=1, EX_MEM__MEM_READ=0 and RS[k]==EX_MEM__RD.
  - Otherwise SRC[k]=2 if RS[k]!=0, MEM_WB__REG_WRITE=1 and RS[k]==MEM_WB__RD.
  - Otherwise SRC[k]=0.
  - EX/MEM has priority over MEM/WB when both match.
- Hazard detection is combinational. `hz` = ID_EX__MEM_READ & ID_EX__REG_WRITE & (ID_EX__RD!=0) & (ID_EX__RD equals any ID__RS[k]).
- The FSM has two states and a counter `cnt` of width clog2(LOAD_LAT+1).
  - IDLE:
    - If `hz` and not FLUSH: assert stall this cycle.
    - If LOAD_LAT>1, go to WAIT with cnt=LOAD_LAT-1; otherwise stay in IDLE.
  - WAIT:
    - Assert stall every cycle and decrement cnt.
    - When cnt==1 and it decrements, return to IDLE.
    - `hz` is not re-evaluated while in WAIT.
- Stall outputs: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1. When not stalled: PC_WRITE=1, IF_ID_WRITE=1, ID_EX_BUBBLE=0.
- FLUSH has priority over everything else. In any state it forces IDLE with cnt=0, and stall outputs are deasserted in that same cycle. A hazard coinciding with FLUSH is ignored.

## Timing
- SRC and stall outputs have zero latency: they are combinational from inputs and current state.
- A hazard detected in cycle t produces exactly LOAD_LAT stalled cycles, t .. t+LOAD_LAT-1. The instruction in ID advances in cycle t+LOAD_LAT.
- Back-to-back hazards: after returning to IDLE, a new `hz` in the very next cycle starts a new stall with no gap cycle.
- Reset:
  - While rst_i=1, the state goes to IDLE, cnt to 0 and both counters to 0 at the clock edge.
  - Stall outputs are forced to their not-stalled values during rst_i=1, so hazards are masked.
  - SRC stays combinational during reset.
- Reset asserted mid-WAIT aborts the stall at the next edge.
- The counters saturate at 0xFFFFFFFF; they do not wrap.

## Configuration
- FWD_PERF_EN defined:
  - STALL_CYCLES increments each clock with stall asserted.
  - FWD_COUNT increments each clock with any SRC[k]!=0.
- FWD_PERF_EN undefined: both ports still exist, are tied to 0, and no counter flops are synthesised.

## Test plan
- Forward priority: NUM_SRC=2, RS0=RS1=5, EX_MEM__RD=5 and MEM_WB__RD=5, both writing -> SRC=2'b01 per field (value 4'b0101).
- x0 and load suppression:
  - RS0=0 with all RDs=0 and writing -> SRC[0]=0.
  - RS0=7, EX_MEM__RD=7 with MEM_READ=1, MEM_WB__RD=7 -> SRC[0]=2.
- Load-use, LOAD_LAT=3: ID_EX load to x9 with ID__RS1=9 at cycle 10 -> PC_WRITE=0 in cycles 10,11,12 and =1 in cycle 13; with FWD_PERF_EN, STALL_CYCLES=3.
- Flush mid-stall, LOAD_LAT=4: hazard at cycle 0, FLUSH=1 at cycle 2 -> PC_WRITE=0 in cycles 0-1 and =1 from cycle 2; state IDLE at cycle 3.
- Reset mid-stall: LOAD_LAT=4, hazard at cycle 0, rst_i=1 at cycle 1 -> stall deasserted in cycle 1; counters read 0 after the edge.
- Back-to-back hazards, LOAD_LAT=2: hazards at cycles 0 and 2 -> stall in cycles 0-3 continuously.
